// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO around a 1R/1W registered-read block RAM.
// A 2-entry output buffer hides the RAM read latency so the output sustains 1 word/cycle.
module bram_fifo_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [WIDTH-1:0]             i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [WIDTH-1:0]             o_out_data,
  output logic [$clog2(DEPTH+3)-1:0]   o_occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(DEPTH + 3);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // RAM storage and its registered read port; contents are never reset.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW-1:0]    w_wr_ptr_next, w_rd_ptr_next;
  logic [CW-1:0]    r_ram_count, w_ram_count_next;
  logic             r_rd_pend, w_rd_pend_next;
  logic [1:0]       r_ob_count, w_ob_count_next;
  logic [WIDTH-1:0] r_ob_data [2];
  logic [WIDTH-1:0] w_ob_data_next [2];

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [2:0]       w_ob_level;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  // Ready tracks only the RAM count; during a flush it is forced high but the push is dropped.
  assign w_in_ready  = !i_rst && (i_flush || (r_ram_count != CNT_FULL));
  assign w_out_valid = (r_ob_count != 2'd0);
  assign w_push      = i_in_valid && w_in_ready && !i_flush;
  assign w_pop       = w_out_valid && i_out_ready && !i_flush;

  // Output-buffer slots committed after this cycle, counting the read already in flight.
  assign w_ob_level  = {1'b0, r_ob_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_issue     = !i_flush && (r_ram_count != '0) && (w_ob_level < 3'd2);

  always_comb begin
    w_wr_ptr_next    = r_wr_ptr;
    w_rd_ptr_next    = r_rd_ptr;
    w_ram_count_next = r_ram_count;
    w_rd_pend_next   = 1'b0;
    w_ob_count_next  = r_ob_count;
    w_ob_data_next   = r_ob_data;
    if (i_flush) begin
      w_wr_ptr_next    = '0;
      w_rd_ptr_next    = '0;
      w_ram_count_next = '0;
      w_ob_count_next  = 2'd0;
    end else begin
      if (w_push) w_wr_ptr_next = ptr_inc(r_wr_ptr);
      if (w_issue) w_rd_ptr_next = ptr_inc(r_rd_ptr);
      w_ram_count_next = r_ram_count + CW'(w_push) - CW'(w_issue);
      w_rd_pend_next   = w_issue;
      // Pop shifts the head out first so the captured word lands behind any survivor.
      if (w_pop) begin
        w_ob_data_next[0] = r_ob_data[1];
        w_ob_count_next   = r_ob_count - 2'd1;
      end
      if (r_rd_pend) begin
        if (w_ob_count_next == 2'd0) begin
          w_ob_data_next[0] = r_rd_data;
        end else begin
          w_ob_data_next[1] = r_rd_data;
        end
        w_ob_count_next = w_ob_count_next + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_count  <= '0;
      r_rd_pend    <= 1'b0;
      r_ob_count   <= 2'd0;
      r_ob_data[0] <= '0;
      r_ob_data[1] <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_ram_count  <= w_ram_count_next;
      r_rd_pend    <= w_rd_pend_next;
      r_ob_count   <= w_ob_count_next;
      r_ob_data[0] <= w_ob_data_next[0];
      r_ob_data[1] <= w_ob_data_next[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_in_data;
    if (w_issue) r_rd_data <= r_mem[r_rd_ptr];
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = r_ob_data[0];
  assign o_occupancy = OW'(r_ram_count) + OW'(r_rd_pend) + OW'(r_ob_count);

  // A read must never target the slot being written, so old-data RDW is never observed.
  a_no_rdw_hazard: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_push && w_issue) |-> (r_wr_ptr != r_rd_ptr));
  a_ram_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    r_ram_count <= CNT_FULL);
  a_ob_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    ({1'b0, r_ob_count} + {2'b00, r_rd_pend}) <= 3'd2);

endmodule
